// File: rtl/alu_issue_sched_pkg.sv
// Shared types for the ALU issue scheduler: the issue packet carried from the
// reservation stations into the execute stage.
package alu_issue_sched_pkg;

    localparam int ISSUE_TAG_W = 5;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [3:0] {
        UOP_ADD, UOP_SUB, UOP_SLL, UOP_SLT, UOP_SLTU, UOP_XOR,
        UOP_SRL, UOP_SRA, UOP_OR, UOP_AND, UOP_LUI, UOP_AUIPC
    } uopc;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
    } imm_type_t;

    typedef struct packed {
        uopc                    uopcode;
        rv32i_word              rs1_v;
        rv32i_word              rs2_v;
        logic [19:0]            packed_imm;
        imm_type_t              imm_type;
        rv32i_word              pc;
        logic [ISSUE_TAG_W-1:0] tag;
    } issue_pkt_t;

endpackage

// File: rtl/alu_issue_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping modulo N, gated by en.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (en && !found && req[IW'(j)]) begin
                gnt[IW'(j)] = 1'b1;
                idx         = IW'(j);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Shares the execute ALU between NUM_REQ requesters through a one-entry issue
// register, with round-robin grant, backpressure, flush and perf counters.
//   state | meaning
//   EMPTY | exe_valid=0, register free for a grant
//   FULL  | exe_valid=1, packet presented to the ALU stage
module alu_issue_sched
    import alu_issue_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = ISSUE_TAG_W,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req_valid,
    input  issue_pkt_t         req_pkt [NUM_REQ],
    output logic [NUM_REQ-1:0] grant,
    output logic               exe_valid,
    output issue_pkt_t         exe_pkt,
    input  logic               exe_ready,
    output logic [CNT_W-1:0]   issue_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (TAG_W != ISSUE_TAG_W) begin : g_tag_w_check
        $error("TAG_W must equal ISSUE_TAG_W carried in issue_pkt_t");
    end

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic             can_issue;
    logic             grant_any;

    // rst_n gates the grant so requesters never dequeue while held in reset.
    assign can_issue = rst_n && !flush && (!exe_valid || exe_ready);
    assign grant_any = |grant;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (can_issue),
        .gnt (grant),
        .idx (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid <= 1'b0;
            exe_pkt   <= '0;
            rr_ptr    <= '0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                exe_valid <= 1'b0;
            end else if (grant_any) begin
                exe_valid <= 1'b1;
                exe_pkt   <= req_pkt[gnt_idx];
            end else if (exe_ready) begin
                exe_valid <= 1'b0;
            end

            if (grant_any)
                rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

            issue_cnt <= issue_cnt + CNT_W'(grant_any);
            stall_cnt <= stall_cnt + CNT_W'(exe_valid && !exe_ready);
        end
    end

endmodule
